// File: rtl/mcpu_soc_mmio_pkg.sv
// mcpu_soc_mmio_pkg: shared constants, FSM states and byte-mask helper for the MMIO fabric.
package mcpu_soc_mmio_pkg;
    localparam int MMIO_PAGE_LSB = 12;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} mmio_state_t;

    function automatic logic [31:0] wren_to_mask(input logic [3:0] wren);
        return {{8{wren[3]}}, {8{wren[2]}}, {8{wren[1]}}, {8{wren[0]}}};
    endfunction
endpackage

// File: rtl/mcpu_soc_mmio_timeout.sv
// mcpu_soc_mmio_timeout: saturating wait-state counter; expired marks the cycle the count reaches LIMIT (LIMIT=0 disables).
module mcpu_soc_mmio_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);
    localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (en && cnt != W'(LIMIT))
            cnt <= cnt + 1'b1;
    end

    assign expired = (LIMIT != 0) && en && (32'(cnt) + 32'd1 == 32'(LIMIT));
endmodule

// File: rtl/mcpu_soc_mmio_fabric.sv
// mcpu_soc_mmio_fabric: registered MMIO fabric with ack wait states, unmapped-page errors and watchdog timeout; MCPU_SOC_MMIO_ERRLOG_EN adds an error log.
module mcpu_soc_mmio_fabric
    import mcpu_soc_mmio_pkg::*;
#(
    parameter int          NSLOTS         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                   clkrst_core_clk,
    input  logic                   clkrst_core_rst_n,
    input  logic                   m_req,
    output logic                   m_ready,
    input  logic [28:0]            m_addr,
    input  logic [3:0]             m_wren,
    input  logic [31:0]            m_wdata,
    output logic                   m_rvalid,
    output logic [31:0]            m_rdata,
    output logic                   m_err,
    output logic [NSLOTS-1:0]      s_sel,
    output logic [9:0]             s_addr,
    output logic [31:0]            s_wmask,
    output logic [31:0]            s_wdata,
    input  logic [32*NSLOTS-1:0]   s_rdata,
    input  logic [NSLOTS-1:0]      s_ack
`ifdef MCPU_SOC_MMIO_ERRLOG_EN
    ,
    output logic [28:0]            err_addr,
    output logic                   err_is_write,
    output logic                   err_timeout,
    output logic [15:0]            err_count
`endif
);
    localparam int PB = MMIO_PAGE_LSB - 2;

    mmio_state_t state, state_n;
    logic [28:0] addr_q;
    logic [3:0] wren_q;
    logic [31:0] wdata_q, rd_sel;
    logic [NSLOTS-1:0] sel;
    logic accept, mapped, ack_hit, timeout;

    assign mapped   = 32'(m_addr[28:PB]) < 32'(NSLOTS);
    assign accept   = (state == ST_IDLE) && m_req;
    assign sel      = NSLOTS'(1) << addr_q[28:PB];
    assign ack_hit  = (state == ST_WAIT) && |(s_ack & sel);
    assign m_ready  = state == ST_IDLE;
    assign m_rvalid = state == ST_RESP;
    assign s_sel    = (state == ST_WAIT) ? sel : '0;
    assign s_wmask  = (state == ST_WAIT) ? wren_to_mask(wren_q) : '0;
    assign s_addr   = addr_q[PB-1:0];
    assign s_wdata  = wdata_q;

    mcpu_soc_mmio_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clkrst_core_clk),
        .rst_n   (clkrst_core_rst_n),
        .en      ((state == ST_WAIT) && !ack_hit),
        .clr     (state != ST_WAIT),
        .expired (timeout)
    );

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NSLOTS; k++)
            rd_sel = rd_sel | (sel[k] ? s_rdata[32*k +: 32] : 32'h0);
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: state_n = m_req ? (mapped ? ST_WAIT : ST_RESP) : ST_IDLE;
            ST_WAIT: state_n = (ack_hit || timeout) ? ST_RESP : ST_WAIT;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (!clkrst_core_rst_n) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            wren_q  <= '0;
            wdata_q <= '0;
            m_rdata <= '0;
            m_err   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q  <= m_addr;
                wren_q  <= m_wren;
                wdata_q <= m_wdata;
            end
            // ack has priority: timeout is only raised when no ack is seen
            if (accept && !mapped) begin
                m_rdata <= ERR_RDATA;
                m_err   <= 1'b1;
            end else if (ack_hit) begin
                m_rdata <= (|wren_q) ? 32'h0 : rd_sel;
                m_err   <= 1'b0;
            end else if (timeout) begin
                m_rdata <= ERR_RDATA;
                m_err   <= 1'b1;
            end
        end
    end

`ifdef MCPU_SOC_MMIO_ERRLOG_EN
    always_ff @(posedge clkrst_core_clk) begin
        if (!clkrst_core_rst_n) begin
            err_addr     <= '0;
            err_is_write <= 1'b0;
            err_timeout  <= 1'b0;
            err_count    <= '0;
        end else if ((accept && !mapped) || timeout) begin
            err_addr     <= timeout ? addr_q : m_addr;
            err_is_write <= timeout ? |wren_q : |m_wren;
            err_timeout  <= timeout;
            err_count    <= (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mcpu_soc_mmio_fabric.sv
// tb_mcpu_soc_mmio_fabric: directed self-checking bench, NSLOTS=8, TIMEOUT_CYCLES=4; checks the error log when MCPU_SOC_MMIO_ERRLOG_EN is defined.
module tb_mcpu_soc_mmio_fabric;
    localparam int NS = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic m_req = 1'b0, m_ready, m_rvalid, m_err;
    logic [28:0] m_addr = '0;
    logic [3:0] m_wren = '0;
    logic [31:0] m_wdata = '0, m_rdata, s_wmask, s_wdata;
    logic [NS-1:0] s_sel, s_ack = '0;
    logic [9:0] s_addr;
    logic [32*NS-1:0] s_rdata;
`ifdef MCPU_SOC_MMIO_ERRLOG_EN
    logic [28:0] err_addr;
    logic err_is_write, err_timeout;
    logic [15:0] err_count;
`endif
    int passed = 0, total = 0;

    mcpu_soc_mmio_fabric #(.NSLOTS(NS), .TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
        .m_req(m_req), .m_ready(m_ready), .m_addr(m_addr), .m_wren(m_wren), .m_wdata(m_wdata),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
        .s_sel(s_sel), .s_addr(s_addr), .s_wmask(s_wmask), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack)
`ifdef MCPU_SOC_MMIO_ERRLOG_EN
        , .err_addr(err_addr), .err_is_write(err_is_write), .err_timeout(err_timeout), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (m_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", m_ready); else passed++;
        total++; if (s_sel !== 8'h00) $display("FAIL reset_sel got=%h exp=00", s_sel); else passed++;
        total++; if (s_wmask !== 32'h0) $display("FAIL reset_wmask got=%h exp=0", s_wmask); else passed++;
        total++; if ({m_rvalid, m_err} !== 2'b00) $display("FAIL reset_rvalid_err got=%b exp=00", {m_rvalid, m_err}); else passed++;
        total++; if (m_rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", m_rdata); else passed++;
`ifdef MCPU_SOC_MMIO_ERRLOG_EN
        total++; if (err_count !== 16'd0) $display("FAIL reset_err_count got=%0d exp=0", err_count); else passed++;
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        @(negedge clk);
        m_req = 1'b1; m_addr = (29'd2 << 10) | 29'h4; m_wren = 4'h0;
        @(negedge clk);
        m_req = 1'b0;
        total++; if (s_sel !== 8'h04) $display("FAIL read_sel got=%h exp=04", s_sel); else passed++;
        total++; if (s_addr !== 10'h4) $display("FAIL read_saddr got=%h exp=004", s_addr); else passed++;
        total++; if (m_ready !== 1'b0) $display("FAIL read_ready_wait got=%b exp=0", m_ready); else passed++;
        s_ack = 8'h04;
        @(negedge clk);
        s_ack = 8'h00;
        total++; if (m_rvalid !== 1'b1) $display("FAIL read_rvalid got=%b exp=1", m_rvalid); else passed++;
        total++; if (m_rdata !== 32'h1234_5678) $display("FAIL read_rdata got=%h exp=12345678", m_rdata); else passed++;
        total++; if (m_err !== 1'b0) $display("FAIL read_err got=%b exp=0", m_err); else passed++;
        total++; if (s_sel !== 8'h00) $display("FAIL read_sel_resp got=%h exp=00", s_sel); else passed++;
        @(negedge clk);
        total++; if ({m_rvalid, m_ready} !== 2'b01) $display("FAIL read_after got=%b exp=01", {m_rvalid, m_ready}); else passed++;
    endtask

    task automatic test_write_wait_states();
        int pulses = 0, bad = 0;
        m_req = 1'b1; m_addr = 29'd5 << 10; m_wren = 4'b0011; m_wdata = 32'hAABB_CCDD;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            m_req = 1'b0; m_wren = 4'h0; m_wdata = 32'h0;
            if (c <= 4) begin
                if (s_sel !== 8'h20 || s_wmask !== 32'h0000_FFFF || s_wdata !== 32'hAABB_CCDD) begin
                    bad++;
                    $display("FAIL write_hold cyc=%0d sel=%h wmask=%h wdata=%h exp 20/0000ffff/aabbccdd", c, s_sel, s_wmask, s_wdata);
                end
                s_ack = (c == 4) ? 8'h20 : 8'h01;
            end else s_ack = 8'h00;
            if (m_rvalid) begin
                pulses++;
                total++; if (c !== 5) $display("FAIL write_rvalid_cycle got=%0d exp=5", c); else passed++;
                total++; if ({m_err, m_rdata} !== 33'h0) $display("FAIL write_resp err=%b rdata=%h exp 0/0", m_err, m_rdata); else passed++;
            end
        end
        total++; if (bad !== 0) $display("FAIL write_hold_count got=%0d exp=0", bad); else passed++;
        total++; if (pulses !== 1) $display("FAIL write_pulses got=%0d exp=1", pulses); else passed++;
    endtask

    task automatic test_unmapped();
        m_req = 1'b1; m_addr = 29'd9 << 10; m_wren = 4'h0;
        @(negedge clk);
        m_req = 1'b0;
        total++; if (s_sel !== 8'h00) $display("FAIL unmapped_sel got=%h exp=00", s_sel); else passed++;
        total++; if ({m_rvalid, m_err} !== 2'b11) $display("FAIL unmapped_resp got=%b exp=11", {m_rvalid, m_err}); else passed++;
        total++; if (m_rdata !== 32'hDEAD_BEEF) $display("FAIL unmapped_rdata got=%h exp=deadbeef", m_rdata); else passed++;
`ifdef MCPU_SOC_MMIO_ERRLOG_EN
        total++; if ({err_timeout, err_count} !== {1'b0, 16'd1}) $display("FAIL unmapped_log to=%b cnt=%0d exp 0/1", err_timeout, err_count); else passed++;
        total++; if (err_addr !== (29'd9 << 10)) $display("FAIL unmapped_log_addr got=%h exp=%h", err_addr, 29'd9 << 10); else passed++;
`endif
        @(negedge clk);
    endtask

    task automatic test_timeout();
        m_req = 1'b1; m_addr = (29'd3 << 10) | 29'h7; m_wren = 4'h0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            m_req = 1'b0;
            total++; if ({s_sel, m_rvalid} !== {8'h08, 1'b0}) $display("FAIL timeout_wait cyc=%0d sel=%h rvalid=%b exp 08/0", c, s_sel, m_rvalid); else passed++;
        end
        @(negedge clk);
        total++; if (s_sel !== 8'h00) $display("FAIL timeout_sel_drop got=%h exp=00", s_sel); else passed++;
        total++; if ({m_rvalid, m_err} !== 2'b11) $display("FAIL timeout_resp got=%b exp=11", {m_rvalid, m_err}); else passed++;
        total++; if (m_rdata !== 32'hDEAD_BEEF) $display("FAIL timeout_rdata got=%h exp=deadbeef", m_rdata); else passed++;
`ifdef MCPU_SOC_MMIO_ERRLOG_EN
        total++; if ({err_timeout, err_is_write, err_count} !== {2'b10, 16'd2}) $display("FAIL timeout_log to=%b wr=%b cnt=%0d exp 1/0/2", err_timeout, err_is_write, err_count); else passed++;
        total++; if (err_addr !== ((29'd3 << 10) | 29'h7)) $display("FAIL timeout_log_addr got=%h", err_addr); else passed++;
`endif
        @(negedge clk);
    endtask

    task automatic test_ack_on_terminal();
        m_req = 1'b1; m_addr = 29'd1 << 10; m_wren = 4'h0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            m_req = 1'b0;
            s_ack = (c == 4) ? 8'h02 : 8'h00;
        end
        @(negedge clk);
        s_ack = 8'h00;
        total++; if ({m_rvalid, m_err} !== 2'b10) $display("FAIL terminal_ack_resp got=%b exp=10", {m_rvalid, m_err}); else passed++;
        total++; if (m_rdata !== 32'hA5A5_0001) $display("FAIL terminal_ack_rdata got=%h exp=a5a50001", m_rdata); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        m_req = 1'b1; m_addr = 29'd4 << 10; m_wren = 4'hF; m_wdata = 32'h5555_AAAA;
        @(negedge clk);
        m_req = 1'b0; m_wren = 4'h0;
        total++; if (s_sel !== 8'h10) $display("FAIL rstwait_sel got=%h exp=10", s_sel); else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if ({s_sel, s_wmask, m_rvalid, m_ready} !== {8'h00, 32'h0, 1'b0, 1'b1}) $display("FAIL rstwait_idle sel=%h wmask=%h rvalid=%b ready=%b", s_sel, s_wmask, m_rvalid, m_ready); else passed++;
        @(negedge clk);
        total++; if (m_rvalid !== 1'b0) $display("FAIL rstwait_no_pulse got=%b exp=0", m_rvalid); else passed++;
        m_req = 1'b1; m_addr = 29'd0 << 10; m_wren = 4'h0;
        @(negedge clk);
        m_req = 1'b0; s_ack = 8'h01;
        @(negedge clk);
        s_ack = 8'h00;
        total++; if ({m_rvalid, m_err, m_rdata} !== {2'b10, 32'hA5A5_0000}) $display("FAIL rstwait_read rv=%b err=%b rdata=%h exp 1/0/a5a50000", m_rvalid, m_err, m_rdata); else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int accepts = 0, done = 0, bad = 0, wc = 0;
        m_addr = 29'd6 << 10; m_wren = 4'h0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            m_req = (c < 11);
            if (m_ready && m_req) accepts++;
            if (m_rvalid) done++;
            if (m_ready && (s_sel != 0 || m_rvalid)) bad++;
            wc = s_sel[6] ? wc + 1 : 0;
            s_ack = (s_sel[6] && wc == 2) ? 8'h40 : 8'h00;
        end
        m_req = 1'b0; s_ack = 8'h00;
        total++; if (accepts !== 3) $display("FAIL b2b_accepts got=%0d exp=3", accepts); else passed++;
        total++; if (done !== 3) $display("FAIL b2b_completions got=%0d exp=3", done); else passed++;
        total++; if (bad !== 0) $display("FAIL b2b_ready_busy got=%0d exp=0", bad); else passed++;
    endtask

    initial begin
        for (int k = 0; k < NS; k++) s_rdata[32*k +: 32] = 32'hA5A5_0000 | 32'(k);
        s_rdata[64 +: 32] = 32'h1234_5678;
        test_reset();
        test_read();
        test_write_wait_states();
        test_unmapped();
        test_timeout();
        test_ack_on_terminal();
        test_reset_mid_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mcpu_soc_mmio_fabric.md
Name: mcpu_soc_mmio_fabric

Overview:
- Parametrised MMIO fabric between the core's MMIO port and NSLOTS peripheral slots, each a 4 KiB page selected by addr[30:12].
- Replaces purely combinational decode with a registered request, a per-slot ack handshake that allows wait states, a bus-error response for unmapped pages, and a watchdog timeout that completes hung accesses with an error.

Parameters:
- NSLOTS, 8, number of peripheral slots; slot k decodes at addr[30:12] == k.
- TIMEOUT_CYCLES, 255, WAIT cycles before forced error completion; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on any error completion.

Ports:
- clkrst_core_clk  in  1  core clock.
- clkrst_core_rst_n  in  1  reset, synchronous, active-low.
- m_req  in  1  master request valid.
- m_ready  out  1  fabric can accept a request; high only in IDLE.
- m_addr  in  29  word address [30:2].
- m_wren  in  4  byte write enables; 0 means read.
- m_wdata  in  32  write data.
- m_rvalid  out  1  one-cycle completion pulse, for reads and writes.
- m_rdata  out  32  read data, valid with m_rvalid.
- m_err  out  1  error flag, valid with m_rvalid.
- s_sel  out  NSLOTS  one-hot slot select.
- s_addr  out  10  latched addr[11:2], shared by all slots.
- s_wmask  out  32  byte-expanded latched m_wren; zero unless in WAIT.
- s_wdata  out  32  latched write data, shared.
- s_rdata  in  32*NSLOTS  slot k read data on bits [32k+31:32k].
- s_ack  in  NSLOTS  slot k completes its access on this cycle.

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE, s_sel=0, s_wmask=0, m_rvalid=0, m_err=0, m_rdata=0, timeout counter=0, ERRLOG state cleared. Reset aborts any in-flight access with no completion pulse.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - m_ready=1.
  - On m_req, latch addr, wren and wdata.
  - If addr[30:12] < NSLOTS: go to WAIT, s_sel[slot]=1 from the next cycle.
  - Otherwise: go to RESP with err=1 and rdata=ERR_RDATA; no slot is selected.
- WAIT:
  - s_sel one-hot and s_wmask/s_addr/s_wdata held stable.
  - The slot commits a write only on the cycle s_sel[k] & s_ack[k].
  - On s_ack[slot]: capture s_rdata slice into m_rdata (0 for writes), err=0, go to RESP.
  - s_ack bits of unselected slots are ignored.
  - Counter increments each WAIT cycle without ack. When the counter reaches TIMEOUT_CYCLES: go to RESP with err=1, rdata=ERR_RDATA, and drop s_sel.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP: m_rvalid=1 for exactly one cycle, then IDLE. Counter clears.
- Latency: request accepted at cycle 0; s_sel active in cycle 1; ack in cycle 1 gives m_rvalid in cycle 2. Each extra wait state adds one cycle. An unmapped access gives m_rvalid in cycle 1.
- m_req while m_ready=0 is ignored; the master must hold the request. Back-to-back accesses give one request every 3 cycles minimum.
- Counter width is $clog2(TIMEOUT_CYCLES+1) with saturation; no wrap.

Optional Feature:
- Macro: MCPU_SOC_MMIO_ERRLOG_EN.
- When defined, adds outputs err_addr[30:2], err_is_write (1), err_timeout (1) and err_count[15:0]. On every error completion these capture the faulting address, the direction and the cause (unmapped=0, timeout=1). err_count saturates at 16'hFFFF.
- When undefined, these ports and registers are absent, with no behaviour change.

Decomposition:
- Package mcpu_soc_mmio_pkg holds:
  - MMIO_PAGE_LSB=12;
  - the FSM state enum;
  - the default ERR_RDATA constant;
  - a function expanding 4-bit wren to a 32-bit mask.
- One natural sub-module: mcpu_soc_mmio_timeout (counter with enable, clear, terminal flag and disable-when-zero).

Test Plan:
- Read slot 2 (m_addr page 2, offset 0x10), s_ack in first WAIT cycle, s_rdata slot2=32'h1234_5678 -> m_rvalid at cycle 2 with m_rdata=32'h1234_5678, m_err=0, s_addr=10'h4.
- Write slot 5, m_wren=4'b0011, wdata=32'hAABB_CCDD, ack after 3 wait cycles -> s_wmask=32'h0000_FFFF held 4 cycles, one m_rvalid with m_err=0, s_sel=8'h20 throughout WAIT.
- Access page 9 with NSLOTS=8 -> no s_sel, m_rvalid at cycle 1 with m_err=1 and m_rdata=32'hDEAD_BEEF; with ERRLOG, err_timeout=0 and err_count=1.
- Slot never acks, TIMEOUT_CYCLES=4 -> s_sel drops after 4 WAIT cycles, m_err=1; with ERRLOG, err_timeout=1. Repeat with ack in exactly the terminal cycle -> m_err=0.
- Assert rst_n=0 mid-WAIT -> next cycle s_sel=0 and IDLE, no m_rvalid; a following read completes normally.
- Hold m_req continuously while a stalled slot is in WAIT -> exactly one acceptance per completion, m_ready low in WAIT/RESP.
